// File: rtl/kmeans_pkg.sv
// Shared types and widths for the k-means centroid update path.
// Slot/sum offset helpers keep the packing rules in one place.
package kmeans_pkg;

    localparam int CENTROID_NUM = 8;
    localparam int COORD_NUM    = 7;
    localparam int ACC_W        = 22;
    localparam int CRD_W        = 13;
    localparam int CNT_W        = 10;
    localparam int ADDR_W       = 8;
    localparam int DATA_W       = COORD_NUM * CRD_W;
    localparam int IDX_W        = $clog2(CENTROID_NUM);
    localparam int CI_W         = $clog2(COORD_NUM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ACC,
        S_WAIT_ACC,
        S_DIV_ISSUE,
        S_DIV_WAIT,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    function automatic int unsigned slot_off(input logic [CI_W-1:0] i);
        return 32'(i) * CRD_W;
    endfunction

    function automatic int unsigned acc_off(input logic [CI_W-1:0] i);
        return 32'(i) * ACC_W;
    endfunction

endpackage

// File: rtl/coord_saturate.sv
// Clamps a divider quotient to stored coordinate width.
// ovf_o flags any quotient that does not fit.
module coord_saturate
    import kmeans_pkg::*;
(
    input  logic [ACC_W-1:0] quot_i,
    output logic [CRD_W-1:0] coord_o,
    output logic             ovf_o
);

    assign ovf_o   = |quot_i[ACC_W-1:CRD_W];
    assign coord_o = ovf_o ? '1 : quot_i[CRD_W-1:0];

endmodule

// File: rtl/centroid_update_ctrl.sv
// End-of-iteration centroid update: sum/count per coordinate via a
// shared divider, saturate, pack, and write to centroid RAM.
module centroid_update_ctrl
    import kmeans_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     sat_flag,
    output logic [CENTROID_NUM-1:0]  empty_flag,
    output logic                     acc_rd_en,
    output logic [IDX_W-1:0]         acc_rd_idx,
    input  logic [COORD_NUM*ACC_W-1:0] acc_rd_sums,
    input  logic [CNT_W-1:0]         acc_rd_count,
    output logic                     div_start,
    output logic [ACC_W-1:0]         div_dividend,
    output logic [CNT_W-1:0]         div_divisor,
    input  logic [ACC_W-1:0]         div_quotient,
    input  logic                     div_done,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata
);

    localparam logic [CI_W-1:0]  LAST_I = CI_W'(COORD_NUM - 1);
    localparam logic [IDX_W-1:0] LAST_C = IDX_W'(CENTROID_NUM - 1);

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           c_q, c_d;
    logic [CI_W-1:0]            i_q, i_d;
    logic [COORD_NUM*ACC_W-1:0] sums_q, sums_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [DATA_W-1:0]          slots_q, slots_d;
    logic                       sat_q, sat_d;
    logic [CENTROID_NUM-1:0]    empty_q, empty_d;

    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       rd_en_q, rd_en_d;
    logic [IDX_W-1:0]           rd_idx_q, rd_idx_d;
    logic                       dstart_q, dstart_d;
    logic [ACC_W-1:0]           dvd_q, dvd_d;
    logic [CNT_W-1:0]           dvs_q, dvs_d;
    logic                       we_q, we_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [DATA_W-1:0]          wdata_q, wdata_d;

    logic [CRD_W-1:0]           sat_coord;
    logic                       sat_ovf;

    coord_saturate u_sat (
        .quot_i  (div_quotient),
        .coord_o (sat_coord),
        .ovf_o   (sat_ovf)
    );

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        i_d     = i_q;
        sums_d  = sums_q;
        cnt_d   = cnt_q;
        slots_d = slots_q;
        sat_d   = sat_q;
        empty_d = empty_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sat_d   = 1'b0;
                    empty_d = '0;
                    c_d     = '0;
                    state_d = S_RD_ACC;
                end
            end
            S_RD_ACC: state_d = S_WAIT_ACC;
            S_WAIT_ACC: begin
                sums_d = acc_rd_sums;
                cnt_d  = acc_rd_count;
                if (acc_rd_count == '0) begin
                    empty_d[c_q] = 1'b1;
                    state_d      = S_NEXT;
                end else begin
                    i_d     = '0;
                    state_d = S_DIV_ISSUE;
                end
            end
            S_DIV_ISSUE: state_d = S_DIV_WAIT;
            S_DIV_WAIT: begin
                if (div_done) begin
                    slots_d[slot_off(i_q) +: CRD_W] = sat_coord;
                    if (sat_ovf) sat_d = 1'b1;
                    if (i_q == LAST_I) begin
                        state_d = S_WRITE;
                    end else begin
                        i_d     = i_q + CI_W'(1);
                        state_d = S_DIV_ISSUE;
                    end
                end
            end
            S_WRITE: state_d = S_NEXT;
            S_NEXT: begin
                if (c_q == LAST_C) begin
                    state_d = S_DONE;
                end else begin
                    c_d     = c_q + IDX_W'(1);
                    state_d = S_RD_ACC;
                end
            end
            S_DONE: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state so they leave flops.
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        rd_en_d  = (state_d == S_RD_ACC);
        rd_idx_d = rd_en_d ? c_d : rd_idx_q;
        dstart_d = (state_d == S_DIV_ISSUE);
        dvd_d    = dstart_d ? sums_d[acc_off(i_d) +: ACC_W] : dvd_q;
        dvs_d    = dstart_d ? cnt_d : dvs_q;
        we_d     = (state_d == S_WRITE);
        addr_d   = we_d ? ADDR_W'(c_d) : '0;
        wdata_d  = we_d ? slots_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            c_q      <= '0;
            i_q      <= '0;
            sums_q   <= '0;
            cnt_q    <= '0;
            slots_q  <= '0;
            sat_q    <= 1'b0;
            empty_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            rd_idx_q <= '0;
            dstart_q <= 1'b0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            i_q      <= i_d;
            sums_q   <= sums_d;
            cnt_q    <= cnt_d;
            slots_q  <= slots_d;
            sat_q    <= sat_d;
            empty_q  <= empty_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_en_q  <= rd_en_d;
            rd_idx_q <= rd_idx_d;
            dstart_q <= dstart_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign sat_flag     = sat_q;
    assign empty_flag   = empty_q;
    assign acc_rd_en    = rd_en_q;
    assign acc_rd_idx   = rd_idx_q;
    assign div_start    = dstart_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;

endmodule

// File: tb/tb_centroid_update_ctrl.sv
// Randomized bench for centroid_update_ctrl against a
// per-centroid sum/count reference model.
module tb_centroid_update_ctrl;
    import kmeans_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       start;
    logic                       busy, done, sat_flag;
    logic [CENTROID_NUM-1:0]    empty_flag;
    logic                       acc_rd_en;
    logic [IDX_W-1:0]           acc_rd_idx;
    logic [COORD_NUM*ACC_W-1:0] acc_rd_sums;
    logic [CNT_W-1:0]           acc_rd_count;
    logic                       div_start;
    logic [ACC_W-1:0]           div_dividend;
    logic [CNT_W-1:0]           div_divisor;
    logic [ACC_W-1:0]           div_quotient;
    logic                       div_done;
    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_wdata;

    always #5 clk = ~clk;

    centroid_update_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .sat_flag     (sat_flag),
        .empty_flag   (empty_flag),
        .acc_rd_en    (acc_rd_en),
        .acc_rd_idx   (acc_rd_idx),
        .acc_rd_sums  (acc_rd_sums),
        .acc_rd_count (acc_rd_count),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .div_done     (div_done),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    logic [ACC_W-1:0]        m_sum [CENTROID_NUM][COORD_NUM];
    logic [CNT_W-1:0]        m_cnt [CENTROID_NUM];
    logic [ACC_W-1:0]        q_dvd [$];
    logic [CNT_W-1:0]        q_dvs [$];
    logic [ADDR_W-1:0]       q_wa  [$];
    logic [DATA_W-1:0]       q_wd  [$];
    int                      exp_cyc;
    logic [CENTROID_NUM-1:0] exp_empty;
    logic                    exp_sat;

    int  lat_mode = 0;
    bit  alt_t    = 1'b0;
    bit  spur_en  = 1'b0;
    bit  div_pend = 1'b0;
    int  cur_c    = 0;

    task automatic fill_const(input int s, input int n);
        for (int c = 0; c < CENTROID_NUM; c++) begin
            m_cnt[c] = CNT_W'(n);
            for (int i = 0; i < COORD_NUM; i++) m_sum[c][i] = ACC_W'(s);
        end
    endtask

    task automatic fill_rand(input bit zeros);
        for (int c = 0; c < CENTROID_NUM; c++) begin
            case ($urandom_range(0, 7))
                0:       m_cnt[c] = zeros ? '0 : CNT_W'(1);
                1, 2:    m_cnt[c] = CNT_W'($urandom_range(1, 3));
                default: m_cnt[c] = CNT_W'($urandom_range(1, 1023));
            endcase
            for (int i = 0; i < COORD_NUM; i++)
                m_sum[c][i] = ($urandom_range(0, 3) == 0) ?
                              ACC_W'($urandom_range(0, 20000)) : ACC_W'($urandom);
        end
    endtask

    task automatic build();
        int unsigned q;
        logic [DATA_W-1:0] w;
        q_dvd.delete(); q_dvs.delete(); q_wa.delete(); q_wd.delete();
        exp_empty = '0;
        exp_sat   = 1'b0;
        exp_cyc   = 1;
        for (int c = 0; c < CENTROID_NUM; c++) begin
            if (m_cnt[c] == 0) begin
                exp_empty[c] = 1'b1;
                exp_cyc += 3;
            end else begin
                exp_cyc += 4 + COORD_NUM * 4;
                w = '0;
                for (int i = 0; i < COORD_NUM; i++) begin
                    q = int'(m_sum[c][i]) / int'(m_cnt[c]);
                    if (q > 8191) begin
                        q = 8191;
                        exp_sat = 1'b1;
                    end
                    w[i*CRD_W +: CRD_W] = CRD_W'(q);
                    q_dvd.push_back(m_sum[c][i]);
                    q_dvs.push_back(m_cnt[c]);
                end
                q_wa.push_back(ADDR_W'(c));
                q_wd.push_back(w);
            end
        end
    endtask

    // Accumulator bank: data appears only the cycle after the read strobe.
    initial begin
        bit pend = 1'b0;
        int pidx = 0;
        forever begin
            @(posedge clk); #1;
            if (pend) begin
                for (int i = 0; i < COORD_NUM; i++)
                    acc_rd_sums[i*ACC_W +: ACC_W] = m_sum[pidx][i];
                acc_rd_count = m_cnt[pidx];
            end else begin
                for (int i = 0; i < COORD_NUM; i++)
                    acc_rd_sums[i*ACC_W +: ACC_W] = ACC_W'($urandom);
                acc_rd_count = CNT_W'($urandom);
            end
            pend = acc_rd_en;
            pidx = int'(acc_rd_idx);
            if (acc_rd_en) cur_c = int'(acc_rd_idx);
        end
    end

    // Divider with selectable latency, optional spurious done pulses.
    initial begin
        int rem = 0;
        bit late = 1'b0;
        logic [ACC_W-1:0] cdvd;
        logic [CNT_W-1:0] cdvs;
        cdvd = '0;
        cdvs = '1;
        div_done = 1'b0;
        div_quotient = '0;
        forever begin
            @(posedge clk); #1;
            div_done = 1'b0;
            div_quotient = ACC_W'($urandom);
            if (!rst_n) begin
                if (div_pend) late = 1'b1;
                div_pend = 1'b0;
            end else if (late) begin
                div_done = 1'b1;
                late = 1'b0;
            end else if (div_pend) begin
                rem--;
                chk("div_hold_dvd", div_dividend, cdvd);
                chk("div_hold_dvs", div_divisor, cdvs);
                if (rem == 0) begin
                    div_done = 1'b1;
                    div_quotient = ACC_W'(cdvd / ACC_W'(cdvs));
                    div_pend = 1'b0;
                end
            end else if (div_start) begin
                if (q_dvd.size() == 0) begin
                    chk("div_extra", 1, 0);
                end else begin
                    cdvd = q_dvd.pop_front();
                    cdvs = q_dvs.pop_front();
                    chk("div_dvd", div_dividend, cdvd);
                    chk("div_dvs", div_divisor, cdvs);
                    case (lat_mode)
                        0: rem = 3;
                        1: begin
                            rem = alt_t ? 20 : 1;
                            alt_t = ~alt_t;
                        end
                        default: rem = $urandom_range(1, 6);
                    endcase
                    div_pend = 1'b1;
                end
            end else if (spur_en && $urandom_range(0, 7) == 0) begin
                div_done = 1'b1;
            end
        end
    end

    initial begin
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        forever begin
            @(posedge clk); #1;
            if (mem_we) begin
                if (q_wa.size() == 0) begin
                    chk("wr_extra", mem_addr, 8'hff);
                end else begin
                    ea = q_wa.pop_front();
                    ed = q_wd.pop_front();
                    chk("wr_addr", mem_addr, ea);
                    chk("wr_data", mem_wdata, ed);
                end
            end
        end
    end

    task automatic run(input bit chk_cyc, input bit inj_start);
        int n = 0;
        bit got = 1'b0;
        build();
        start = 1'b1;
        while (n < 20000 && !got) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (n == 1) begin
                chk("run_busy", busy, 1);
                chk("run_sat_clr", sat_flag, 0);
                chk("run_empty_clr", empty_flag, 0);
            end
            if (done) got = 1'b1;
            else if (inj_start && $urandom_range(0, 15) == 0) start = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", got, 1);
        if (chk_cyc) chk("done_cycle", n, exp_cyc);
        chk("busy_in_done", busy, 1);
        chk("sat_flag", sat_flag, exp_sat);
        chk("empty_flag", empty_flag, exp_empty);
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("busy_after", busy, 0);
        chk("wr_left", q_wa.size(), 0);
        chk("div_left", q_dvd.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sat"}, sat_flag, 0);
        chk({tag, "_empty"}, empty_flag, 0);
        chk({tag, "_rd_en"}, acc_rd_en, 0);
        chk({tag, "_dstart"}, div_start, 0);
        chk({tag, "_dvd"}, div_dividend, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        lat_mode = 0;
        fill_const(400, 4);
        run(1'b1, 1'b0);

        fill_rand(1'b0);
        m_cnt[2] = '0;
        run(1'b1, 1'b0);
        chk("empty_c2", empty_flag, 8'b0000_0100);

        fill_const(400, 4);
        m_sum[0][0] = 22'h3FFFFF;
        m_cnt[0] = 10'd1;
        run(1'b1, 1'b0);

        lat_mode = 1;
        fill_const(400, 4);
        run(1'b0, 1'b0);

        lat_mode = 2;
        spur_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            fill_rand(1'b1);
            run(1'b0, 1'b1);
        end

        fill_rand(1'b0);
        build();
        start = 1'b1;
        n = 0;
        while (n < 5000 && !(div_pend && cur_c == 5)) begin
            @(posedge clk); #2;
            start = 1'b0;
            n++;
        end
        chk("reach_c5", n < 5000, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        q_dvd.delete(); q_dvs.delete(); q_wa.delete(); q_wd.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_we", mem_we, 0);
        chk("post_rst_busy", busy, 0);
        fill_rand(1'b0);
        run(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/centroid_update_ctrl.md
# centroid_update_ctrl

Sequences the end-of-iteration centroid update in the k-means engine. For every centroid it reads the 7 per-coordinate accumulated sums and the member count, and time-shares one external divider to compute sum/count per coordinate. It saturates each quotient to coordinate width, packs the results into one memory word and writes it to centroid memory. It sits between the accumulator bank and the centroid RAM and is started once per iteration by the top-level k-means FSM.

## Interface
- `centroid_num`, 8: number of centroids processed per run
- `coord_num`, 7: coordinates per centroid
- `accum_cord_width`, 22: width of one accumulated coordinate sum
- `cordinate_width`, 13: width of one stored coordinate
- `count_width`, 10: width of member count
- `addrWidth`, 8: centroid RAM address width
- `dataWidth`, 91: centroid RAM word width (= coord_num*cordinate_width)

Ports:
- `clk` in 1: single clock, all logic rising-edge
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: one-cycle pulse, begin update run
- `busy` out 1: run in progress
- `done` out 1: one-cycle pulse at end of run
- `sat_flag` out 1: sticky, some quotient saturated this run; cleared on start
- `empty_flag` out centroid_num: bit c set if centroid c had count 0 this run; cleared on start
- `acc_rd_en` out 1: accumulator read strobe
- `acc_rd_idx` out $clog2(centroid_num): centroid index to read
- `acc_rd_sums` in coord_num*accum_cord_width: sums, coord i at [(i+1)*22-1:i*22], valid the cycle after acc_rd_en
- `acc_rd_count` in count_width: member count, same timing
- `div_start` out 1: one-cycle pulse, launch division
- `div_dividend` out accum_cord_width: held stable from div_start until div_done
- `div_divisor` out count_width: held stable from div_start until div_done
- `div_quotient` in accum_cord_width: valid while div_done high
- `div_done` in 1: one-cycle pulse, arbitrary latency ≥1 cycle after div_start
- `mem_we` out 1: centroid RAM write strobe
- `mem_addr` out addrWidth: centroid index, zero-extended
- `mem_wdata` out dataWidth: packed centroid, coord i at [(i+1)*13-1:i*13]

## Operation
- States: IDLE, RD_ACC, WAIT_ACC, DIV_ISSUE, DIV_WAIT, WRITE, NEXT, DONE.
- IDLE: `start` → clear flags, c=0, go RD_ACC. `start` while not IDLE is ignored.
- RD_ACC: assert `acc_rd_en`, `acc_rd_idx`=c → WAIT_ACC.
- WAIT_ACC: latch sums and count into local registers. If count==0, set empty_flag[c] and go NEXT with no divider use and no write (centroid keeps its old RAM value). Otherwise set i=0 → DIV_ISSUE.
- DIV_ISSUE: pulse `div_start` with sum i and count → DIV_WAIT.
- DIV_WAIT: on `div_done`, saturate the quotient: if quotient ≥ 2^cordinate_width, store all-ones and set sat_flag; else store quotient[cordinate_width-1:0] into slot i. Then go DIV_ISSUE if i<coord_num-1 (i++), else WRITE. `div_done` in any other state is ignored.
- WRITE: `mem_we`=1, `mem_addr`=c, `mem_wdata`=packed slots → NEXT.
- NEXT: if c==centroid_num-1 → DONE, else c++ → RD_ACC.
- DONE: pulse `done` → IDLE.
- Arithmetic is unsigned throughout; no rounding (quotient truncated by divider).

## Timing
- Reset values: all outputs 0; state IDLE; slot registers 0. Reset mid-run aborts immediately. No partial write is completed. A late `div_done` after reset release is ignored.
- `busy` is high from the cycle after `start` through the DONE cycle inclusive.
- Per non-empty centroid: 2 + coord_num*(1+L) + 2 cycles, with L the divider latency. Per empty centroid: 3 cycles. DONE adds 1.
- All handshake outputs are registered. `mem_we`, `div_start`, `acc_rd_en` and `done` are single-cycle pulses.

## Structure
- Package `kmeans_pkg`: state enum, width constants, packing-offset function for coordinate slot i.
- Sub-module `coord_saturate`: combinational accum_cord_width→cordinate_width saturation with overflow flag. Everything else stays in one module.

## Test plan
- Single run, divider model L=3, all counts 4, sums 400 → 8 writes, each slot 100 (0x064); `done` at cycle 8*(4+28)+1 after start; flags 0.
- Centroid 2 count 0 → no write at addr 2, empty_flag=8'b0000_0100, other addresses written normally.
- Sum 0x3FFFFF, count 1 → slot 0x1FFF, sat_flag=1; sat_flag cleared by next `start`.
- Variable divider latency 1 and 20 interleaved; dividend/divisor held stable until `div_done` → identical results to the L=3 run.
- `start` pulsed during busy, spurious `div_done` in RD_ACC → ignored, result unchanged.
- `rst_n` low during DIV_WAIT of centroid 5 → outputs 0 asynchronously; a fresh `start` after release completes a full 8-centroid run.
